// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters and optional gshare indexing.
// Lookup is combinational; resolved branches update the table on the next clock edge.
module branch_predictor #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned ENTRIES = 64,
    parameter int unsigned TAG_W   = 8,
    parameter int unsigned GHR_W   = 0,
    parameter int unsigned CNT_W   = 16,
    localparam int unsigned IDX_W  = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    // Fetch-side lookup
    input  logic [XLEN-1:0]  lookup_pc,
    output logic             pred_taken,
    output logic [XLEN-1:0]  pred_target,
    output logic [IDX_W-1:0] lookup_idx,
    // Execute-side resolution
    input  logic             upd_valid,
    input  logic [XLEN-1:0]  upd_pc,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken,
    input  logic [XLEN-1:0]  upd_target,
    input  logic             upd_pred_taken,
    input  logic [XLEN-1:0]  upd_pred_target,
    output logic             mispredict,
    output logic [XLEN-1:0]  redirect_pc,
    // Statistics
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    logic             valid_q [ENTRIES];
    logic [1:0]       ctr_q   [ENTRIES];
    logic [TAG_W-1:0] tag_q   [ENTRIES];
    logic [XLEN-1:0]  tgt_q   [ENTRIES];

    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

    logic [IDX_W-1:0] ghr_ext;
    logic [TAG_W-1:0] lookup_tag;
    logic             lookup_hit;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_hit;
    logic [1:0]       ctr_d;

    // Global history: shifts in resolved outcomes only, never speculative ones.
    if (GHR_W > 0) begin : g_gshare
        logic [GHR_W-1:0] ghr_q, ghr_d;
        logic [GHR_W:0]   ghr_shift;

        always_comb begin
            ghr_shift = {ghr_q, upd_taken};
            ghr_d     = upd_valid ? ghr_shift[GHR_W-1:0] : ghr_q;
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                ghr_q <= '0;
            end else begin
                ghr_q <= ghr_d;
            end
        end

        assign ghr_ext = IDX_W'(ghr_q);
    end else begin : g_bimodal
        assign ghr_ext = '0;
    end

    // Lookup path
    always_comb begin
        lookup_idx  = lookup_pc[IDX_W+1:2] ^ ghr_ext;
        lookup_tag  = lookup_pc[IDX_W+TAG_W+1:IDX_W+2];
        lookup_hit  = valid_q[lookup_idx] && (tag_q[lookup_idx] == lookup_tag);
        pred_taken  = lookup_hit && ctr_q[lookup_idx][1];
        pred_target = pred_taken ? tgt_q[lookup_idx] : lookup_pc + XLEN'(4);
    end

    // Resolution path
    always_comb begin
        mispredict  = upd_valid &&
                      ((upd_taken != upd_pred_taken) ||
                       (upd_taken && upd_pred_taken && (upd_target != upd_pred_target)));
        redirect_pc = upd_taken ? upd_target : upd_pc + XLEN'(4);
    end

    always_comb begin
        upd_tag = upd_pc[IDX_W+TAG_W+1:IDX_W+2];
        upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
        ctr_d   = ctr_q[upd_idx];
        if (upd_taken) begin
            if (ctr_q[upd_idx] != 2'b11) begin
                ctr_d = ctr_q[upd_idx] + 2'b01;
            end
        end else begin
            if (ctr_q[upd_idx] != 2'b00) begin
                ctr_d = ctr_q[upd_idx] - 2'b01;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= 2'b01;
            end
        end else if (upd_valid) begin
            if (upd_hit) begin
                ctr_q[upd_idx] <= ctr_d;
            end else if (upd_taken) begin
                valid_q[upd_idx] <= 1'b1;
                ctr_q[upd_idx]   <= 2'b10;
            end
        end
    end

    // Tag and target need no reset: they are only observed through a valid entry.
    // On a hit the stored tag already equals upd_tag, so rewriting it is harmless.
    always_ff @(posedge clk) begin
        if (upd_valid && upd_taken) begin
            tag_q[upd_idx] <= upd_tag;
            tgt_q[upd_idx] <= upd_target;
        end
    end

    // Statistics counters saturate at all-ones
    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (upd_valid && !(&branch_cnt_q)) begin
            branch_cnt_d = branch_cnt_q + CNT_W'(1);
        end
        if (mispredict && !(&mispred_cnt_q)) begin
            mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign branch_cnt  = branch_cnt_q;
    assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed scenarios plus randomized traffic against a table model.
// Instance a is bimodal with 16-bit stats; instance b is gshare (4-bit history) with 4-bit stats.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] lookup_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [5:0]  upd_idx_a, upd_idx_b;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;

    logic        a_pred_taken, b_pred_taken;
    logic [31:0] a_pred_target, b_pred_target;
    logic [5:0]  a_lookup_idx, b_lookup_idx;
    logic        a_mispredict, b_mispredict;
    logic [31:0] a_redirect_pc, b_redirect_pc;
    logic [15:0] a_branch_cnt, a_mispred_cnt;
    logic [3:0]  b_branch_cnt, b_mispred_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    branch_predictor #(.XLEN(32), .ENTRIES(64), .TAG_W(8), .GHR_W(0), .CNT_W(16)) u_dut_a (
        .clk             (clk),
        .rst             (rst),
        .lookup_pc       (lookup_pc),
        .pred_taken      (a_pred_taken),
        .pred_target     (a_pred_target),
        .lookup_idx      (a_lookup_idx),
        .upd_valid       (upd_valid),
        .upd_pc          (upd_pc),
        .upd_idx         (upd_idx_a),
        .upd_taken       (upd_taken),
        .upd_target      (upd_target),
        .upd_pred_taken  (upd_pred_taken),
        .upd_pred_target (upd_pred_target),
        .mispredict      (a_mispredict),
        .redirect_pc     (a_redirect_pc),
        .branch_cnt      (a_branch_cnt),
        .mispred_cnt     (a_mispred_cnt)
    );

    branch_predictor #(.XLEN(32), .ENTRIES(64), .TAG_W(8), .GHR_W(4), .CNT_W(4)) u_dut_b (
        .clk             (clk),
        .rst             (rst),
        .lookup_pc       (lookup_pc),
        .pred_taken      (b_pred_taken),
        .pred_target     (b_pred_target),
        .lookup_idx      (b_lookup_idx),
        .upd_valid       (upd_valid),
        .upd_pc          (upd_pc),
        .upd_idx         (upd_idx_b),
        .upd_taken       (upd_taken),
        .upd_target      (upd_target),
        .upd_pred_taken  (upd_pred_taken),
        .upd_pred_target (upd_pred_target),
        .mispredict      (b_mispredict),
        .redirect_pc     (b_redirect_pc),
        .branch_cnt      (b_branch_cnt),
        .mispred_cnt     (b_mispred_cnt)
    );

    // Reference model: one table per instance, counters kept as plain integers 0..3
    bit          m_valid [2][64];
    int          m_tag   [2][64];
    logic [31:0] m_tgt   [2][64];
    int          m_ctr   [2][64];
    int          m_ghr   [2];
    int          m_bc    [2];
    int          m_mc    [2];
    int          m_cmax  [2] = '{65535, 15};

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 64; i++) begin
                m_valid[k][i] = 1'b0;
                m_ctr[k][i]   = 1;
            end
            m_ghr[k] = 0;
            m_bc[k]  = 0;
            m_mc[k]  = 0;
        end
    endtask

    function automatic int m_idx(input int k, input logic [31:0] pc);
        return int'((pc >> 2) & 32'd63) ^ m_ghr[k];
    endfunction

    function automatic int m_tagof(input logic [31:0] pc);
        return int'((pc >> 8) & 32'd255);
    endfunction

    function automatic bit m_pred(input int k, input logic [31:0] pc);
        int i = m_idx(k, pc);
        return m_valid[k][i] && (m_tag[k][i] == m_tagof(pc)) && (m_ctr[k][i] >= 2);
    endfunction

    function automatic logic [31:0] m_target(input int k, input logic [31:0] pc);
        return m_pred(k, pc) ? m_tgt[k][m_idx(k, pc)] : pc + 32'd4;
    endfunction

    function automatic bit m_mis();
        if (!upd_valid) return 1'b0;
        if (upd_taken != upd_pred_taken) return 1'b1;
        return upd_taken && (upd_target != upd_pred_target);
    endfunction

    task automatic m_update(input int k, input int ui, input bit mis);
        bit hit = m_valid[k][ui] && (m_tag[k][ui] == m_tagof(upd_pc));
        if (hit) begin
            m_ctr[k][ui] = upd_taken ? ((m_ctr[k][ui] < 3) ? m_ctr[k][ui] + 1 : 3)
                                     : ((m_ctr[k][ui] > 0) ? m_ctr[k][ui] - 1 : 0);
            if (upd_taken) m_tgt[k][ui] = upd_target;
        end else if (upd_taken) begin
            m_valid[k][ui] = 1'b1;
            m_tag[k][ui]   = m_tagof(upd_pc);
            m_tgt[k][ui]   = upd_target;
            m_ctr[k][ui]   = 2;
        end
        if (k == 1) m_ghr[k] = ((m_ghr[k] << 1) | int'(upd_taken)) & 15;
        if (m_bc[k] < m_cmax[k]) m_bc[k]++;
        if (mis && m_mc[k] < m_cmax[k]) m_mc[k]++;
    endtask

    task automatic drive(input logic [31:0] lpc, input bit uv, input logic [31:0] upc,
                         input bit t, input logic [31:0] tgt, input bit pt,
                         input logic [31:0] ptgt);
        lookup_pc       = lpc;
        upd_valid       = uv;
        upd_pc          = upc;
        upd_taken       = t;
        upd_target      = tgt;
        upd_pred_taken  = pt;
        upd_pred_target = ptgt;
        upd_idx_a       = 6'(m_idx(0, upc));
        upd_idx_b       = 6'(m_idx(1, upc));
        #1;
    endtask

    // Compare everything against the model, then advance one clock and update the model.
    task automatic tick();
        bit mis = m_mis();
        int ia  = m_idx(0, upd_pc);
        int ib  = m_idx(1, upd_pc);
        check_eq("a_pred_taken", a_pred_taken, m_pred(0, lookup_pc));
        check_eq("a_pred_target", a_pred_target, m_target(0, lookup_pc));
        check_eq("a_lookup_idx", a_lookup_idx, m_idx(0, lookup_pc));
        check_eq("b_pred_taken", b_pred_taken, m_pred(1, lookup_pc));
        check_eq("b_pred_target", b_pred_target, m_target(1, lookup_pc));
        check_eq("b_lookup_idx", b_lookup_idx, m_idx(1, lookup_pc));
        check_eq("a_mispredict", a_mispredict, mis);
        check_eq("b_mispredict", b_mispredict, mis);
        if (mis) begin
            check_eq("a_redirect", a_redirect_pc, upd_taken ? upd_target : upd_pc + 32'd4);
            check_eq("b_redirect", b_redirect_pc, upd_taken ? upd_target : upd_pc + 32'd4);
        end
        check_eq("a_branch_cnt", a_branch_cnt, m_bc[0]);
        check_eq("a_mispred_cnt", a_mispred_cnt, m_mc[0]);
        check_eq("b_branch_cnt", b_branch_cnt, m_bc[1]);
        check_eq("b_mispred_cnt", b_mispred_cnt, m_mc[1]);
        @(posedge clk);
        if (upd_valid) begin
            m_update(0, ia, mis);
            m_update(1, ib, mis);
        end
        @(negedge clk);
    endtask

    // Resolve a branch on pc using the model's own fetch-time prediction
    task automatic resolve(input logic [31:0] pc, input bit t, input logic [31:0] tgt);
        drive(pc, 1'b1, pc, t, tgt, m_pred(0, pc), m_target(0, pc));
        tick();
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] pc = 32'h100 + 32'(4 * $urandom_range(0, 15));
        if ($urandom_range(0, 4) == 0) pc = pc + 32'h4000;
        return pc;
    endfunction

    initial begin
        m_reset();
        rst = 1'b0;
        drive(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        #10;
        rst = 1'b1;
        @(negedge clk);

        // Reset state
        drive(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        check_eq("rst_pred_taken", a_pred_taken, 1'b0);
        check_eq("rst_pred_target", a_pred_target, 32'h104);
        check_eq("rst_branch_cnt", a_branch_cnt, 16'd0);
        check_eq("rst_mispred_cnt", a_mispred_cnt, 16'd0);
        tick();

        // First taken branch allocates the entry
        drive(32'h100, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
        check_eq("first_mispredict", a_mispredict, 1'b1);
        check_eq("first_redirect", a_redirect_pc, 32'h80);
        tick();
        drive(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        check_eq("alloc_pred_taken", a_pred_taken, 1'b1);
        check_eq("alloc_pred_target", a_pred_target, 32'h80);
        tick();

        // Saturation: 4 taken, then one not-taken keeps taken, a second flips it
        for (int i = 0; i < 4; i++) resolve(32'h100, 1'b1, 32'h80);
        resolve(32'h100, 1'b0, 32'h0);
        drive(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        check_eq("sat_still_taken", a_pred_taken, 1'b1);
        tick();
        resolve(32'h100, 1'b0, 32'h0);
        drive(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        check_eq("sat_now_not_taken", a_pred_taken, 1'b0);
        tick();

        // Wrong-target jump
        resolve(32'h100, 1'b1, 32'h80);
        resolve(32'h100, 1'b1, 32'h80);
        drive(32'h100, 1'b1, 32'h100, 1'b1, 32'hC0, 1'b1, 32'h80);
        check_eq("wrongtgt_mispredict", a_mispredict, 1'b1);
        check_eq("wrongtgt_redirect", a_redirect_pc, 32'hC0);
        tick();
        drive(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        check_eq("wrongtgt_new_target", a_pred_target, 32'hC0);
        tick();

        // Aliasing: same index, different tag
        drive(32'h200, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        check_eq("alias_idx", a_lookup_idx, 6'd0);
        check_eq("alias_pred_taken", a_pred_taken, 1'b0);
        // Gshare: history after three taken resolutions moves pc 0x100 off index 0
        check_eq("gshare_idx", b_lookup_idx, 6'd7);
        tick();

        // Lookup and update to the same index in one cycle returns pre-update state
        drive(32'h140, 1'b1, 32'h140, 1'b1, 32'h300, 1'b0, 32'h144);
        check_eq("nobypass_pred", a_pred_taken, 1'b0);
        tick();

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            logic [31:0] lpc = rand_pc();
            logic [31:0] upc = rand_pc();
            bit uv = ($urandom_range(0, 3) != 0);
            bit t  = ($urandom_range(0, 99) < (upc[2] ? 85 : 20));
            logic [31:0] tgt = ($urandom & 32'h0000_0FFC);
            bit pt = m_pred(0, upc);
            logic [31:0] ptgt = m_target(0, upc);
            if ($urandom_range(0, 9) == 0) pt = !pt;
            if ($urandom_range(0, 9) == 0) ptgt = tgt;
            drive(lpc, uv, upc, t, tgt, pt, ptgt);
            tick();
        end

        // Asynchronous reset between clock edges
        resolve(32'h100, 1'b1, 32'h80);
        resolve(32'h100, 1'b1, 32'h80);
        drive(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        check_eq("pre_rst_trained", a_pred_taken, 1'b1);
        #1;
        rst = 1'b0;
        #1;
        check_eq("async_rst_pred", a_pred_taken, 1'b0);
        check_eq("async_rst_bcnt", a_branch_cnt, 16'd0);
        check_eq("async_rst_mcnt", a_mispred_cnt, 16'd0);
        check_eq("async_rst_b_bcnt", b_branch_cnt, 4'd0);
        m_reset();
        #1;
        rst = 1'b1;
        tick();

        // 20 updates on the 4-bit statistics instance saturate at 15
        for (int i = 0; i < 20; i++) resolve(32'h180 + 32'(4 * (i % 4)), 1'b1, 32'h40);
        drive(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        check_eq("b_cnt_saturated", b_branch_cnt, 4'd15);
        check_eq("a_cnt_twenty", a_branch_cnt, 16'd20);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, errors so far %0d", n_errors);
        $fatal(1, "timeout");
    end

endmodule
